// File: rtl/soml_pkg.sv
// soml_pkg: shared defaults, FSM encoding and accumulator width for the SOML datapath
package soml_pkg;
  localparam int Q_DEF   = 8;
  localparam int N_DEF   = 16;
  localparam int LEN_DEF = 4;
  typedef enum logic {S_ACC = 1'b0, S_HOLD = 1'b1} state_t;
  function automatic int acc_w(input int n, input int len);
    return n + $clog2(len);
  endfunction
  localparam int ACC_W_DEF = acc_w(N_DEF, LEN_DEF);
endpackage

// File: rtl/sat_trunc.sv
// sat_trunc: saturate a signed IW-bit value to OW bits and flag when clipping occurred
module sat_trunc #(
  parameter int IW = 18,
  parameter int OW = 16
) (
  input  logic [IW-1:0] i_d,
  output logic [OW-1:0] o_q,
  output logic          o_ovf
);
  logic [IW-OW:0] w_top;
  // value fits only when every bit above the output sign bit copies that sign bit
  always_comb begin
    w_top = i_d[IW-1:OW-1];
    o_ovf = !((&w_top) || !(|w_top));
    o_q   = o_ovf ? (i_d[IW-1] ? {1'b1, {(OW-1){1'b0}}} : {1'b0, {(OW-1){1'b1}}}) : i_d[OW-1:0];
  end
endmodule

// File: rtl/cdot_acc.sv
// cdot_acc: accumulate LEN complex product beats, saturate to N bits and hold the result until taken
module cdot_acc
  import soml_pkg::*;
#(
  parameter int Q   = Q_DEF,
  parameter int N   = N_DEF,
  parameter int LEN = LEN_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_pr,
  input  logic [N-1:0] in_pi,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_sr,
  output logic [N-1:0] out_si,
  output logic         out_ovf
);
  localparam int AW = acc_w(N, LEN);
  localparam int CW = $clog2(LEN);
  if (LEN < 2 || Q < 0 || Q > N) begin : g_bad_param
    $error("cdot_acc: LEN must be >= 2 and Q within 0..N");
  end
  state_t               r_state;
  logic [CW-1:0]        r_cnt;
  logic signed [AW-1:0] r_acc_r, r_acc_i;
  logic [N-1:0]         r_sr, r_si;
  logic                 r_ovf;
  logic signed [AW-1:0] w_ext_r, w_ext_i, w_nxt_r, w_nxt_i;
  logic [N-1:0]         w_sat_r, w_sat_i;
  logic                 w_ovf_r, w_ovf_i, w_last;
  // first beat of a vector restarts the sums instead of adding to stale contents
  always_comb begin
    w_ext_r = AW'(signed'(in_pr));
    w_ext_i = AW'(signed'(in_pi));
    w_nxt_r = (r_cnt == '0 ? '0 : r_acc_r) + w_ext_r;
    w_nxt_i = (r_cnt == '0 ? '0 : r_acc_i) + w_ext_i;
    w_last  = r_cnt == CW'(LEN - 1);
  end
  sat_trunc #(.IW(AW), .OW(N)) u_sat_r (.i_d(w_nxt_r), .o_q(w_sat_r), .o_ovf(w_ovf_r));
  sat_trunc #(.IW(AW), .OW(N)) u_sat_i (.i_d(w_nxt_i), .o_q(w_sat_i), .o_ovf(w_ovf_i));
  // ACC/HOLD control, beat counter, accumulators and the held result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_ACC;
      r_cnt   <= '0;
      r_acc_r <= '0;
      r_acc_i <= '0;
      r_sr    <= '0;
      r_si    <= '0;
      r_ovf   <= 1'b0;
    end else if (r_state == S_ACC) begin
      if (in_valid) begin
        r_acc_r <= w_nxt_r;
        r_acc_i <= w_nxt_i;
        r_cnt   <= w_last ? '0 : r_cnt + 1'b1;
        if (w_last) begin
          r_state <= S_HOLD;
          r_sr    <= w_sat_r;
          r_si    <= w_sat_i;
          r_ovf   <= w_ovf_r | w_ovf_i;
        end
      end
    end else if (out_ready) begin
      r_state <= S_ACC;
    end
  end
  // handshake flags decode straight from the state register, so out_ready never reaches in_ready
  always_comb begin
    in_ready  = r_state == S_ACC;
    out_valid = r_state == S_HOLD;
    out_sr    = r_sr;
    out_si    = r_si;
    out_ovf   = r_ovf;
  end
endmodule

// File: tb/tb_cdot_acc.sv
// tb_cdot_acc: directed-vector bench for cdot_acc with hand-computed sums
module tb_cdot_acc;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_pr = '0;
  logic [15:0] in_pi = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_sr, out_si;
  logic        out_ovf;
  int          n_err = 0;
  int          n_chk = 0;
  logic [15:0] nom_pr [4] = '{16'hffdd, 16'hfe7d, 16'h004d, 16'hfef8};
  logic [15:0] nom_pi [4] = '{16'h00c1, 16'h000c, 16'h003c, 16'h0128};

  cdot_acc #(.Q(8), .N(16), .LEN(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_pr(in_pr), .in_pi(in_pi), .out_valid(out_valid), .out_ready(out_ready),
    .out_sr(out_sr), .out_si(out_si), .out_ovf(out_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) if (!rst && in_ready && out_valid) chk("excl", 1, 0);

  task automatic beat(input logic [15:0] pr, input logic [15:0] pi);
    chk("rdy_beat", in_ready, 1);
    in_pr = pr;
    in_pi = pi;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic nominal(input int gap);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) chk("vld_early", out_valid, 0);
      beat(nom_pr[i], nom_pi[i]);
      if (i < 3) repeat (gap) begin @(posedge clk); #1; end
    end
  endtask

  task automatic expect_out(input string tag, input logic [15:0] sr, input logic [15:0] si, input logic ovf);
    int t = 0;
    while (!out_valid && t < 20) begin @(posedge clk); #1; t++; end
    chk({tag, "_lat"}, t, 0);
    chk({tag, "_vld"}, out_valid, 1);
    chk({tag, "_rdy"}, in_ready, 0);
    chk({tag, "_sr"}, out_sr, sr);
    chk({tag, "_si"}, out_si, si);
    chk({tag, "_ovf"}, out_ovf, ovf);
  endtask

  task automatic take();
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    chk("take_rdy", in_ready, 1);
    chk("take_vld", out_valid, 0);
  endtask

  initial begin
    #12;
    chk("rst_rdy", in_ready, 1);
    chk("rst_vld", out_valid, 0);
    chk("rst_sr", out_sr, 0);
    chk("rst_si", out_si, 0);
    chk("rst_ovf", out_ovf, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    nominal(0);
    expect_out("nom", 16'hfd9f, 16'h0231, 1'b0);
    in_valid = 1'b1;
    in_pr = 16'h1234;
    in_pi = 16'h4321;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("bp_sr", out_sr, 16'hfd9f);
      chk("bp_si", out_si, 16'h0231);
      chk("bp_rdy", in_ready, 0);
      chk("bp_vld", out_valid, 1);
    end
    in_valid = 1'b0;
    take();
    for (int i = 0; i < 4; i++) beat(16'h7fff, 16'h0001);
    expect_out("psat", 16'h7fff, 16'h0004, 1'b1);
    take();
    for (int i = 0; i < 4; i++) beat(16'h8000, 16'h0000);
    expect_out("nsat", 16'h8000, 16'h0000, 1'b1);
    take();
    nominal(3);
    expect_out("gap", 16'hfd9f, 16'h0231, 1'b0);
    take();
    beat(16'h7000, 16'h7000);
    beat(16'h7000, 16'h7000);
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    chk("mid_rst_rdy", in_ready, 1);
    chk("mid_rst_sr", out_sr, 0);
    @(posedge clk); #1;
    nominal(0);
    expect_out("mrst", 16'hfd9f, 16'h0231, 1'b0);
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    chk("hold_rst_vld", out_valid, 0);
    chk("hold_rst_rdy", in_ready, 1);
    chk("hold_rst_sr", out_sr, 0);
    chk("hold_rst_si", out_si, 0);
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) beat(16'h0100, 16'hff00);
    expect_out("post", 16'h0400, 16'hfc00, 1'b0);
    take();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
